// File: rtl/axi_llc_pkg.sv
// axi_llc_pkg: shared LLC types (eviction policy) and the victim-selector LFSR step
package axi_llc_pkg;
  typedef enum logic [1:0] {EVICT_PLRU, EVICT_RAND, EVICT_RR} evict_policy_e;
  localparam logic [15:0] LfsrTaps = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrTaps : 16'h0);
  endfunction
endpackage

// File: rtl/axi_llc_plru_tree.sv
// axi_llc_plru_tree: lock-aware tree-PLRU walk (walk_tree_i/lock_i -> one-hot victim_o) and path update (upd_tree_i/upd_way_i -> upd_tree_o)
module axi_llc_plru_tree #(
  parameter int unsigned Ways = 8
) (
  input  logic [Ways-2:0] walk_tree_i,
  input  logic [Ways-1:0] lock_i,
  output logic [Ways-1:0] victim_o,
  input  logic [Ways-2:0] upd_tree_i,
  input  logic [Ways-1:0] upd_way_i,
  output logic [Ways-2:0] upd_tree_o
);
  localparam int L = $clog2(Ways);
  localparam int TW = Ways - 1;
  always_comb begin
    int pos, node, sz, base;
    logic l_lock, r_lock, right;
    logic [Ways-1:0] lk;
    logic [TW-1:0] t;
    pos = 0;
    node = 0;
    sz = 0;
    base = 0;
    l_lock = 1'b0;
    r_lock = 1'b0;
    right = 1'b0;
    lk = '0;
    t = '0;
    for (int d = 0; d < L; d++) begin
      node = (1 << d) - 1 + pos;
      sz = int'(Ways) >> (d + 1);
      base = 2 * pos * sz;
      l_lock = 1'b1;
      r_lock = 1'b1;
      for (int i = 0; i < int'(Ways); i++) begin
        lk = lock_i >> i;
        if (i >= base && i < base + sz) l_lock &= lk[0];
        if (i >= base + sz && i < base + 2 * sz) r_lock &= lk[0];
      end
      t = walk_tree_i >> node;
      right = r_lock ? 1'b0 : l_lock ? 1'b1 : t[0];
      pos = 2 * pos + int'(right);
    end
    victim_o = Ways'(1) << pos;
  end
  always_comb begin
    int idx, pos, node, s;
    logic [Ways-1:0] w;
    logic b;
    idx = 0;
    pos = 0;
    node = 0;
    s = 0;
    w = '0;
    b = 1'b0;
    for (int i = 0; i < int'(Ways); i++) begin
      w = upd_way_i >> i;
      if (w[0]) idx = i;
    end
    upd_tree_o = upd_tree_i;
    for (int d = 0; d < L; d++) begin
      node = (1 << d) - 1 + pos;
      s = idx >> (L - 1 - d);
      b = s[0];
      upd_tree_o = (upd_tree_o & ~(TW'(1) << node)) | (TW'(!b) << node);
      pos = 2 * pos + int'(b);
    end
  end
endmodule

// File: rtl/axi_llc_evict_unit.sv
// axi_llc_evict_unit: LLC victim selector (PLRU/RAND/RR); req_* set view in, registered res_* one-hot way/write-back/error out, touch_* hit updates
module axi_llc_evict_unit import axi_llc_pkg::*; #(
  parameter int unsigned Ways = 8,
  parameter int unsigned NumSets = 256,
  parameter evict_policy_e Policy = EVICT_PLRU,
  parameter logic [15:0] LfsrSeed = 16'hACE1,
  localparam int unsigned IdxW = $clog2(NumSets)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [IdxW-1:0] req_index_i,
  input  logic [Ways-1:0] tag_valid_i,
  input  logic [Ways-1:0] tag_dirty_i,
  input  logic [Ways-1:0] spm_lock_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [Ways-1:0] res_way_o,
  output logic            res_evict_o,
  output logic            res_err_o,
  input  logic            touch_valid_i,
  input  logic [IdxW-1:0] touch_index_i,
  input  logic [Ways-1:0] touch_way_i
);
  localparam int unsigned L = $clog2(Ways);
  localparam int unsigned TW = Ways - 1;
  logic [TW-1:0] walk_tree, touch_tree_q, touch_tree_d, chain_tree, alloc_tree;
  logic [Ways-1:0] walk_way, chk_way, free, free_way, pol_way, sel_way;
  logic [15:0] lfsr_q;
  logic [L-1:0] rr_q, sel_idx;
  logic accept, no_free, is_err, same_set;
  function automatic logic [Ways-1:0] scan(input logic [Ways-1:0] lock, input logic [L-1:0] start);
    logic [Ways-1:0] rot, pick;
    rot = (~lock >> start) | (~lock << (Ways - start));
    pick = rot & (~rot + Ways'(1));
    return (pick << start) | (pick >> (Ways - start));
  endfunction
  assign req_ready_o = ~res_valid_o | res_ready_i;
  assign accept = req_valid_i & req_ready_o;
  assign same_set = touch_valid_i & (touch_index_i == req_index_i);
  // a same-set touch is folded in before the allocation so the allocation wins on shared nodes
  assign chain_tree = same_set ? touch_tree_d : walk_tree;
  always_comb begin
    free = ~(tag_valid_i | spm_lock_i);
    free_way = free & (~free + Ways'(1));
    no_free = ~|free;
    is_err = no_free & (&spm_lock_i);
    pol_way = Policy == EVICT_PLRU ? walk_way : scan(spm_lock_i, Policy == EVICT_RAND ? lfsr_q[L-1:0] : rr_q);
    sel_way = !no_free ? free_way : is_err ? '0 : pol_way;
    sel_idx = '0;
    for (int i = 0; i < int'(Ways); i++) if (sel_way[i]) sel_idx = L'(i);
  end
  axi_llc_plru_tree #(.Ways(Ways)) u_walk (
    .walk_tree_i(walk_tree),
    .lock_i     (spm_lock_i),
    .victim_o   (walk_way),
    .upd_tree_i (touch_tree_q),
    .upd_way_i  (touch_way_i),
    .upd_tree_o (touch_tree_d)
  );
  // the walk side re-reads the freshly updated tree unlocked; it must never land on the way just allocated
  axi_llc_plru_tree #(.Ways(Ways)) u_alloc (
    .walk_tree_i(alloc_tree),
    .lock_i     ('0),
    .victim_o   (chk_way),
    .upd_tree_i (chain_tree),
    .upd_way_i  (sel_way),
    .upd_tree_o (alloc_tree)
  );
  if (Policy == EVICT_PLRU) begin : g_plru
    logic [TW-1:0] plru_q [NumSets];
    assign walk_tree = plru_q[req_index_i];
    assign touch_tree_q = plru_q[touch_index_i];
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < int'(NumSets); s++) plru_q[s] <= '0;
      end else begin
        if (touch_valid_i) plru_q[touch_index_i] <= touch_tree_d;
        if (accept & ~is_err) plru_q[req_index_i] <= alloc_tree;
      end
    end
  end else begin : g_noplru
    assign walk_tree = '0;
    assign touch_tree_q = '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_way_o <= '0;
      res_evict_o <= 1'b0;
      res_err_o <= 1'b0;
      lfsr_q <= LfsrSeed;
      rr_q <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (accept) begin
        res_valid_o <= 1'b1;
        res_way_o <= sel_way;
        res_evict_o <= no_free & ~is_err & |(sel_way & tag_dirty_i);
        res_err_o <= is_err;
      end else if (res_ready_i) begin
        res_valid_o <= 1'b0;
      end
      if (accept & no_free & ~is_err & (Policy == EVICT_RR)) rr_q <= sel_idx + L'(1);
    end
  end
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(touch_valid_i && Policy == EVICT_PLRU) || $onehot(touch_way_i));
      assert (!res_valid_o || $onehot0(res_way_o));
      assert (!(accept && !is_err && Policy == EVICT_PLRU) || chk_way != sel_way);
    end
  end
endmodule

// File: tb/tb_axi_llc_evict_unit.sv
// tb_axi_llc_evict_unit: directed bench for PLRU, RR and RAND instances of axi_llc_evict_unit
module tb_axi_llc_evict_unit;
  import axi_llc_pkg::*;
  localparam logic [3:0] F = 4'b1111;
  logic clk = 1'b0, rst;
  logic req_valid, res_ready, touch_valid;
  logic [3:0] req_index, touch_index, tag_valid, tag_dirty, spm_lock, touch_way;
  logic p_ready, p_valid, p_evict, p_err;
  logic r_ready, r_valid, r_evict, r_err;
  logic n_ready, n_valid, n_evict, n_err_o;
  logic [3:0] p_way, r_way, n_way;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  axi_llc_evict_unit #(.Ways(4), .NumSets(16), .Policy(EVICT_PLRU)) u_plru (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(p_ready), .req_index_i(req_index),
    .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty), .spm_lock_i(spm_lock), .res_valid_o(p_valid),
    .res_ready_i(res_ready), .res_way_o(p_way), .res_evict_o(p_evict), .res_err_o(p_err),
    .touch_valid_i(touch_valid), .touch_index_i(touch_index), .touch_way_i(touch_way));
  axi_llc_evict_unit #(.Ways(4), .NumSets(16), .Policy(EVICT_RR)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(r_ready), .req_index_i(req_index),
    .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty), .spm_lock_i(spm_lock), .res_valid_o(r_valid),
    .res_ready_i(res_ready), .res_way_o(r_way), .res_evict_o(r_evict), .res_err_o(r_err),
    .touch_valid_i(touch_valid), .touch_index_i(touch_index), .touch_way_i(touch_way));
  axi_llc_evict_unit #(.Ways(4), .NumSets(16), .Policy(EVICT_RAND)) u_rand (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(n_ready), .req_index_i(req_index),
    .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty), .spm_lock_i(spm_lock), .res_valid_o(n_valid),
    .res_ready_i(res_ready), .res_way_o(n_way), .res_evict_o(n_evict), .res_err_o(n_err_o),
    .touch_valid_i(touch_valid), .touch_index_i(touch_index), .touch_way_i(touch_way));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [3:0] idx, input logic [3:0] v, input logic [3:0] d, input logic [3:0] l);
    req_valid = 1'b1;
    req_index = idx;
    tag_valid = v;
    tag_dirty = d;
    spm_lock = l;
    @(negedge clk);
  endtask
  task automatic touch(input logic [3:0] idx, input logic [3:0] way);
    touch_valid = 1'b1;
    touch_index = idx;
    touch_way = way;
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b1;
    touch_valid = 1'b0;
    req_index = '0;
    touch_index = '0;
    touch_way = 4'b0001;
    tag_valid = '0;
    tag_dirty = '0;
    spm_lock = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {7'b0, p_valid}, 8'd0);
    chk("rst_way", {4'b0, p_way}, 8'd0);
    chk("rst_flags", {6'b0, p_evict, p_err}, 8'd0);
    chk("rst_ready", {7'b0, p_ready}, 8'd1);
    rst = 1'b0;
    go(5, F, 0, 0); chk("plru_1", {4'b0, p_way}, 8'h1); chk("lat_1", {7'b0, p_valid}, 8'd1);
    go(5, F, 0, 0); chk("plru_2", {4'b0, p_way}, 8'h4);
    go(5, F, 0, 0); chk("plru_3", {4'b0, p_way}, 8'h2);
    go(5, F, 0, 0); chk("plru_4", {4'b0, p_way}, 8'h8); chk("plru_4_ev", {7'b0, p_evict}, 8'd0);
    go(5, 4'b1011, 0, 0); chk("free_way", {4'b0, p_way}, 8'h4); chk("free_ev", {7'b0, p_evict}, 8'd0);
    chk("free_ready", {7'b0, p_ready}, 8'd1);
    go(5, 4'b1011, 4'b0001, 4'b0100); chk("lock_way", {4'b0, p_way}, 8'h1); chk("lock_ev", {7'b0, p_evict}, 8'd1);
    go(9, F, 4'b0100, 4'b0011); chk("redir_way", {4'b0, p_way}, 8'h4); chk("redir_ev", {7'b0, p_evict}, 8'd1);
    go(5, F, 0, F); chk("err_flag", {7'b0, p_err}, 8'd1); chk("err_way", {4'b0, p_way}, 8'h0);
    chk("err_ev", {7'b0, p_evict}, 8'd0);
    go(5, F, 0, 0); chk("post_err", {4'b0, p_way}, 8'h8); chk("post_err_flag", {7'b0, p_err}, 8'd0);
    go(5, F, 0, 0); chk("pre_hold", {4'b0, p_way}, 8'h2);
    res_ready = 1'b0;
    touch(5, 4'b0100);
    @(negedge clk);
    touch_valid = 1'b0;
    chk("hold_1", {p_ready, p_valid, 2'b0, p_way}, 8'h42);
    @(negedge clk); chk("hold_2", {p_ready, p_valid, 2'b0, p_way}, 8'h42);
    @(negedge clk); chk("hold_3", {p_ready, p_valid, 2'b0, p_way}, 8'h42);
    res_ready = 1'b1;
    touch(5, 4'b0001);
    go(5, F, 0, 0); touch_valid = 1'b0; chk("touch_same", {4'b0, p_way}, 8'h1);
    go(5, F, 0, 0); chk("avoid_0", {4'b0, p_way}, 8'h8);
    touch(9, 4'b0001);
    go(5, F, 0, 0); touch_valid = 1'b0; chk("touch_diff_req", {4'b0, p_way}, 8'h2);
    go(9, F, 0, 0); chk("touch_diff_set", {4'b0, p_way}, 8'h8);
    go(5, F, 0, 0); chk("alloc_diff_set", {4'b0, p_way}, 8'h4);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_valid", {5'b0, p_valid, r_valid, n_valid}, 8'd0);
    rst = 1'b0;
    go(3, F, 0, 0); chk("rr_1", {4'b0, r_way}, 8'h1); chk("rand_1", {4'b0, n_way}, 8'h2);
    go(3, F, 0, 4'b0001); chk("rr_2", {4'b0, r_way}, 8'h2); chk("rand_2", {4'b0, n_way}, 8'h2);
    go(3, F, 0, F); chk("rr_err", {3'b0, r_err, r_way}, 8'h10);
    go(3, F, 0, 0); chk("rr_3", {4'b0, r_way}, 8'h4);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_midrst", {7'b0, r_valid}, 8'd0);
    rst = 1'b0;
    go(3, F, 0, 0); chk("rr_post_rst", {4'b0, r_way}, 8'h1); chk("rand_post_rst", {4'b0, n_way}, 8'h2);
    go(3, F, 0, 4'b0010); chk("rr_lock", {4'b0, r_way}, 8'h4);
    req_valid = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
